// File: rtl/sn74ls163_ctrl.sv
// sn74ls163_ctrl: run controller for two cascaded '163 counters (8-bit chain).
// Define CTRL163_RELOAD_EN to honour periodic (auto-reload on rco); otherwise every run is one-shot.
module sn74ls163_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] period,
  input  logic       periodic,
  input  logic       rco,
  output logic [7:0] d,
  output logic       cload,
  output logic       cclr,
  output logic       ep,
  output logic       et,
  output logic       busy,
  output logic       tick,
  output logic       done,
  output logic       err,
  output logic [7:0] ticks
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, nxt;
  logic [7:0] preg;
  logic pmode, pmode_in, reload, abq, accept, elapse;
`ifdef CTRL163_RELOAD_EN
  assign pmode_in = periodic;
  assign reload = state == RUN && pmode && rco;
`else
  logic unused_periodic;
  assign unused_periodic = periodic;
  assign pmode_in = 1'b0;
  assign reload = 1'b0;
`endif
  always_comb begin
    accept = state == IDLE && start && period != 8'd0;
    elapse = state == RUN && rco;
    nxt = abort ? IDLE :
          state == IDLE ? (accept ? LOAD : IDLE) :
          state == LOAD ? RUN :
          state == RUN ? (rco && !pmode ? DONE : RUN) :
          (start ? DONE : IDLE);
  end
  assign busy = state == LOAD || state == RUN;
  assign done = state == DONE;
  assign ep = state == RUN;
  assign et = state == RUN;
  // Reload shares the rco edge so periodic ticks stay exactly P clocks apart.
  assign cload = !(state == LOAD || reload);
  assign cclr = clr && !abq;
  assign d = 8'd0 - preg;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      preg <= 8'd0;
      pmode <= 1'b0;
      abq <= 1'b0;
      tick <= 1'b0;
      err <= 1'b0;
      ticks <= 8'd0;
    end else begin
      state <= nxt;
      abq <= abort;
      tick <= !abort && elapse;
      err <= !abort && state == IDLE && start && period == 8'd0;
      if (!abort && accept) begin
        preg <= period;
        pmode <= pmode_in;
        ticks <= 8'd0;
      end else if (!abort && elapse) ticks <= ticks + 8'd1;
    end
  end
endmodule

// File: tb/tb_sn74ls163_ctrl.sv
// tb_sn74ls163_ctrl: directed bench with a behavioural pair of cascaded '163 counters driven by the controller.
module tb_sn74ls163_ctrl;
`ifdef CTRL163_RELOAD_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  logic clk = 1'b0, clr = 1'b0, start = 1'b0, abort = 1'b0, periodic = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] d, ticks;
  logic cload, cclr, ep, et, busy, tick, done, err, rco;
  logic [7:0] cnt = 8'd0;
  int total = 0, bad = 0, exp_ticks = 0;
  sn74ls163_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .period(period),
    .periodic(periodic), .rco(rco), .d(d), .cload(cload), .cclr(cclr),
    .ep(ep), .et(et), .busy(busy), .tick(tick), .done(done), .err(err),
    .ticks(ticks)
  );
  always #5 clk = ~clk;
  // Counter chain: clear beats load beats count; rco gated by et as on the real part.
  always @(posedge clk)
    if (!cclr) cnt <= 8'd0;
    else if (!cload) cnt <= d;
    else if (ep && et) cnt <= cnt + 8'd1;
  assign rco = et && cnt == 8'hff;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int p, input bit per, input int n);
    bit rl, t, ld;
    rl = REL && per;
    start = 1'b1;
    period = 8'(p);
    periodic = per;
    step();
    start = 1'b0;
    exp_ticks = 0;
    chk($sformatf("p%0d load busy", p), {7'd0, busy}, 8'd1);
    chk($sformatf("p%0d load cload", p), {7'd0, cload}, 8'd0);
    chk($sformatf("p%0d load ep", p), {7'd0, ep}, 8'd0);
    chk($sformatf("p%0d load d", p), d, 8'(256 - p));
    chk($sformatf("p%0d load ticks", p), ticks, 8'd0);
    for (int k = 1; k <= n; k++) begin
      step();
      t = k >= p + 1 && (rl ? (k - p - 1) % p == 0 : k == p + 1);
      ld = rl && k >= p && (k - p) % p == 0;
      if (t) exp_ticks++;
      chk($sformatf("p%0d k%0d tick", p, k), {7'd0, tick}, {7'd0, t});
      chk($sformatf("p%0d k%0d ticks", p, k), ticks, 8'(exp_ticks));
      chk($sformatf("p%0d k%0d cload", p, k), {7'd0, cload}, {7'd0, !ld});
      chk($sformatf("p%0d k%0d done", p, k), {7'd0, done}, {7'd0, !rl && k == p + 1});
      chk($sformatf("p%0d k%0d busy", p, k), {7'd0, busy}, {7'd0, rl || k <= p});
    end
  endtask
  task automatic do_abort(input string tag);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk({tag, " busy"}, {7'd0, busy}, 8'd0);
    chk({tag, " tick"}, {7'd0, tick}, 8'd0);
    chk({tag, " done"}, {7'd0, done}, 8'd0);
    chk({tag, " cclr"}, {7'd0, cclr}, 8'd0);
    chk({tag, " ticks"}, ticks, 8'(exp_ticks));
    step();
    chk({tag, " cclr after"}, {7'd0, cclr}, 8'd1);
    chk({tag, " cnt cleared"}, cnt, 8'd1 & {8{ep}});
  endtask
  initial begin
    step();
    step();
    chk("rst busy", {7'd0, busy}, 8'd0);
    chk("rst tick", {7'd0, tick}, 8'd0);
    chk("rst done", {7'd0, done}, 8'd0);
    chk("rst err", {7'd0, err}, 8'd0);
    chk("rst ticks", ticks, 8'd0);
    chk("rst ep", {7'd0, ep}, 8'd0);
    chk("rst cload", {7'd0, cload}, 8'd1);
    chk("rst cclr", {7'd0, cclr}, 8'd0);
    chk("rst d", d, 8'd0);
    clr = 1'b1;
    step();
    chk("idle cclr", {7'd0, cclr}, 8'd1);
    run(5, 1'b0, 8);
    start = 1'b1;
    period = 8'd0;
    step();
    start = 1'b0;
    chk("p0 err", {7'd0, err}, 8'd1);
    chk("p0 busy", {7'd0, busy}, 8'd0);
    chk("p0 ticks kept", ticks, 8'd1);
    step();
    chk("p0 err pulse", {7'd0, err}, 8'd0);
    chk("p0 stays idle", {7'd0, busy}, 8'd0);
    run(3, 1'b1, 31);
    do_abort("abort p3");
    run(2, 1'b1, 5);
    do_abort("abort p2");
    run(4, 1'b1, 3);
    step();
    chk("p4 rco high", {7'd0, rco}, 8'd1);
    do_abort("abort on rco");
    run(2, 1'b1, 3);
    #3;
    clr = 1'b0;
    #1;
    chk("midrst cclr", {7'd0, cclr}, 8'd0);
    chk("midrst busy", {7'd0, busy}, 8'd0);
    chk("midrst tick", {7'd0, tick}, 8'd0);
    chk("midrst done", {7'd0, done}, 8'd0);
    chk("midrst ticks", ticks, 8'd0);
    chk("midrst ep", {7'd0, ep}, 8'd0);
    chk("midrst cload", {7'd0, cload}, 8'd1);
    chk("midrst d", d, 8'd0);
    step();
    clr = 1'b1;
    step();
    chk("postrst idle", {7'd0, busy}, 8'd0);
    exp_ticks = 0;
    run(1, 1'b1, 6);
    do_abort("abort p1");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
